// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one AXI4-Lite master port between three cache line-transfer
// requesters and breaks each line transfer into LINE_WORDS single-word
// AXI4-Lite transactions, one outstanding beat at a time.
//
// Requesters (i_req bit / grant bit):
//   [0] icache fill      - read,  address i_addr_i
//   [1] dcache fill      - read,  address i_addr_d
//   [2] dcache write-back - write, address i_addr_wb, data i_wb_data
// Fixed priority wb > dcache fill > icache fill. Requests are only looked at
// while idle. Once a transfer starts, its grant is held until its done pulse.
//
// Ports:
//   i_clk, i_arst          clock, synchronous active-high reset
//   i_req, i_addr_*        level requests and their line addresses
//   i_wb_data              write-back word at o_word_idx (combinational read)
//   o_grant                one-hot current owner, 0 when idle
//   o_word_idx             beat index within the line
//   o_fill_data, o_fill_we fill word for the owning cache (zero-latency R pass-through)
//   o_done                 one-hot, one-cycle completion pulse
//   AR/R, AW/W/B           AXI4-Lite master channels (strobes implied all ones)
//
// Optional feature (macro MEM_ARB_ERR_EN): adds o_err, a sticky flag set by any
// R or B handshake whose response is non-zero; cleared only by reset.

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic [2:0]                    i_req,
    input  logic [ADDR_W-1:0]             i_addr_i,
    input  logic [ADDR_W-1:0]             i_addr_d,
    input  logic [ADDR_W-1:0]             i_addr_wb,
    input  logic [31:0]                   i_wb_data,
    output logic [2:0]                    o_grant,
    output logic [$clog2(LINE_WORDS)-1:0] o_word_idx,
    output logic [31:0]                   o_fill_data,
    output logic                          o_fill_we,
    output logic [2:0]                    o_done,
    output logic [ADDR_W-1:0]             o_araddr,
    output logic                          o_arvalid,
    input  logic                          i_arready,
    input  logic [31:0]                   i_rdata,
    input  logic [1:0]                    i_rresp,
    input  logic                          i_rvalid,
    output logic                          o_rready,
    output logic [ADDR_W-1:0]             o_awaddr,
    output logic                          o_awvalid,
    input  logic                          i_awready,
    output logic [31:0]                   o_wdata,
    output logic                          o_wvalid,
    input  logic                          i_wready,
    input  logic [1:0]                    i_bresp,
    input  logic                          i_bvalid,
    output logic                          o_bready
`ifdef MEM_ARB_ERR_EN
    ,
    output logic                          o_err
`endif
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    // Clears the byte-within-line bits so the latched base is line aligned.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        grant, grant_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              aw_ok, aw_ok_nxt;
    logic              w_ok, w_ok_nxt;
    logic [ADDR_W-1:0] beat_addr;
    logic              last_beat;

    // Base is line aligned, so OR-ing in the word offset equals base + idx*4.
    assign beat_addr = base | ADDR_W'({idx, 2'b00});
    assign last_beat = (idx == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state <= IDLE;
            grant <= '0;
            base  <= '0;
            idx   <= '0;
            aw_ok <= 1'b0;
            w_ok  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            base  <= base_nxt;
            idx   <= idx_nxt;
            aw_ok <= aw_ok_nxt;
            w_ok  <= w_ok_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        base_nxt    = base;
        idx_nxt     = idx;
        aw_ok_nxt   = aw_ok;
        w_ok_nxt    = w_ok;

        o_grant     = grant;
        o_word_idx  = idx;
        o_fill_data = '0;
        o_fill_we   = 1'b0;
        o_done      = '0;
        o_araddr    = beat_addr;
        o_arvalid   = 1'b0;
        o_rready    = 1'b0;
        o_awaddr    = beat_addr;
        o_awvalid   = 1'b0;
        o_wdata     = i_wb_data;
        o_wvalid    = 1'b0;
        o_bready    = 1'b0;

        case (state)
            IDLE: begin
                idx_nxt   = '0;
                aw_ok_nxt = 1'b0;
                w_ok_nxt  = 1'b0;
                if (i_req[2]) begin
                    grant_nxt = 3'b100;
                    base_nxt  = i_addr_wb & BASE_MASK;
                    state_nxt = WR_REQ;
                end else if (i_req[1]) begin
                    grant_nxt = 3'b010;
                    base_nxt  = i_addr_d & BASE_MASK;
                    state_nxt = RD_ADDR;
                end else if (i_req[0]) begin
                    grant_nxt = 3'b001;
                    base_nxt  = i_addr_i & BASE_MASK;
                    state_nxt = RD_ADDR;
                end
            end

            RD_ADDR: begin
                o_arvalid = 1'b1;
                if (i_arready) begin
                    state_nxt = RD_DATA;
                end
            end

            RD_DATA: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    o_fill_data = i_rdata;
                    o_fill_we   = 1'b1;
                    idx_nxt     = idx + IDX_W'(1);
                    state_nxt   = last_beat ? DONE : RD_ADDR;
                end
            end

            WR_REQ: begin
                // AW and W complete independently; each valid drops once its
                // own handshake has happened and the beat moves on when both have.
                o_awvalid = !aw_ok;
                o_wvalid  = !w_ok;
                if ((aw_ok || i_awready) && (w_ok || i_wready)) begin
                    aw_ok_nxt = 1'b0;
                    w_ok_nxt  = 1'b0;
                    state_nxt = WR_RESP;
                end else begin
                    aw_ok_nxt = aw_ok || i_awready;
                    w_ok_nxt  = w_ok || i_wready;
                end
            end

            WR_RESP: begin
                o_bready = 1'b1;
                if (i_bvalid) begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = last_beat ? DONE : WR_REQ;
                end
            end

            DONE: begin
                o_done    = grant;
                grant_nxt = '0;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

`ifdef MEM_ARB_ERR_EN
    logic err;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            err <= 1'b0;
        end else if ((state == RD_DATA && i_rvalid && i_rresp != 2'b00) ||
                     (state == WR_RESP && i_bvalid && i_bresp != 2'b00)) begin
            err <= 1'b1;
        end
    end

    assign o_err = err;
`else
    // Responses are not acted on in this build.
    logic resp_unused;
    assign resp_unused = ^{i_rresp, i_bresp};
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LW     = 4;
    localparam logic [31:0] RD_XOR = 32'hA5A5_0000;

    logic        clk;
    logic        arst;
    logic [2:0]  req;
    logic [31:0] addr_i, addr_d, addr_wb;
    logic [31:0] wb_data, wb_base;
    logic [2:0]  grant;
    logic [1:0]  word_idx;
    logic [31:0] fill_data;
    logic        fill_we;
    logic [2:0]  done;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
`ifdef MEM_ARB_ERR_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int ar_dly = 1;
    int aw_dly = 0;
    int w_dly  = 0;

    logic [31:0] q_ar[$];
    logic [63:0] q_fill[$];
    logic [31:0] q_aw[$];
    logic [63:0] q_w[$];
    logic [1:0]  q_b[$];
    logic [2:0]  q_done[$];

    // dcache data array read: word value = wb_base + index
    assign wb_data = wb_base | {30'd0, word_idx};

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_WORDS(LW)) dut (
        .i_clk(clk), .i_arst(arst), .i_req(req),
        .i_addr_i(addr_i), .i_addr_d(addr_d), .i_addr_wb(addr_wb),
        .i_wb_data(wb_data), .o_grant(grant), .o_word_idx(word_idx),
        .o_fill_data(fill_data), .o_fill_we(fill_we), .o_done(done),
        .o_araddr(araddr), .o_arvalid(arvalid), .i_arready(arready),
        .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready),
        .o_awaddr(awaddr), .o_awvalid(awvalid), .i_awready(awready),
        .o_wdata(wdata), .o_wvalid(wvalid), .i_wready(wready),
        .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready)
`ifdef MEM_ARB_ERR_EN
        , .o_err(err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected event, value 0x%0h", name, act);
    endtask

    task automatic push_read(input logic [2:0] g, input logic [31:0] base,
                             input int nbeats, input bit with_done);
        for (int k = 0; k < nbeats; k++) begin
            q_ar.push_back(base + 32'(4 * k));
            q_fill.push_back({27'd0, g, 2'(k), (base + 32'(4 * k)) ^ RD_XOR});
        end
        if (with_done) q_done.push_back(g);
    endtask

    task automatic push_write(input logic [31:0] base, input logic [31:0] wbase);
        for (int k = 0; k < LW; k++) begin
            q_aw.push_back(base + 32'(4 * k));
            q_w.push_back({30'd0, 2'(k), wbase + 32'(k)});
            q_b.push_back(2'(k));
        end
        q_done.push_back(3'b100);
    endtask

    task automatic wait_done(input logic [2:0] who);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 3'b000 && n < 400);
        if (done == 3'b000) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got none expected 0x%0h", who);
        end
        req = req & ~done;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_grant"},   64'(grant),    64'd0);
        check({tag, "_idx"},     64'(word_idx), 64'd0);
        check({tag, "_arvalid"}, 64'(arvalid),  64'd0);
        check({tag, "_rready"},  64'(rready),   64'd0);
        check({tag, "_awvalid"}, 64'(awvalid),  64'd0);
        check({tag, "_wvalid"},  64'(wvalid),   64'd0);
        check({tag, "_bready"},  64'(bready),   64'd0);
        check({tag, "_fill_we"}, 64'(fill_we),  64'd0);
        check({tag, "_done"},    64'(done),     64'd0);
        check({tag, "_araddr"},  64'(araddr),   64'd0);
        check({tag, "_awaddr"},  64'(awaddr),   64'd0);
    endtask

    // AXI4-Lite slave: decides at the negedge, drives just after the posedge.
    initial begin : slave
        int  ar_wait, aw_wait, w_wait;
        bit  r_pend, aw_got, w_got;
        logic [31:0] r_addr;
        logic n_arready, n_rvalid, n_awready, n_wready, n_bvalid;
        logic [31:0] n_rdata;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        r_pend = 0; aw_got = 0; w_got = 0; r_addr = 0;
        forever begin
            @(negedge clk);
            n_arready = 0;
            n_awready = 0;
            n_wready  = 0;
            n_rvalid  = rvalid && !rready;
            n_rdata   = rdata;
            n_bvalid  = bvalid && !bready;
            if (arst) begin
                n_rvalid = 0; n_bvalid = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0;
                r_pend = 0; aw_got = 0; w_got = 0;
            end else begin
                if (arvalid && arready) begin
                    ar_wait = 0;
                    r_pend  = 1;
                    r_addr  = araddr;
                end else if (r_pend) begin
                    n_rvalid = 1;
                    n_rdata  = r_addr ^ RD_XOR;
                    r_pend   = 0;
                end
                if (arvalid && !arready) begin
                    ar_wait++;
                    n_arready = (ar_wait >= ar_dly);
                end
                if (awvalid && awready) begin
                    aw_got = 1; aw_wait = 0;
                end else if (awvalid) begin
                    aw_wait++;
                    n_awready = (aw_wait >= aw_dly);
                end
                if (wvalid && wready) begin
                    w_got = 1; w_wait = 0;
                end else if (wvalid) begin
                    w_wait++;
                    n_wready = (w_wait >= w_dly);
                end
                if (aw_got && w_got) begin
                    n_bvalid = 1;
                    aw_got = 0;
                    w_got  = 0;
                end
            end
            @(posedge clk);
            #1;
            arready = n_arready;
            rvalid  = n_rvalid;
            rdata   = n_rdata;
            awready = n_awready;
            wready  = n_wready;
            bvalid  = n_bvalid;
        end
    end

    // Monitor: pops the expected value whenever the DUT presents an event.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (arvalid && arready) begin
                if (q_ar.size() == 0) unexpected("ar_addr", 64'(araddr));
                else check("ar_addr", 64'(araddr), 64'(q_ar.pop_front()));
            end
            if (fill_we) begin
                if (q_fill.size() == 0) unexpected("fill", {27'd0, grant, word_idx, fill_data});
                else check("fill{grant,idx,data}", {27'd0, grant, word_idx, fill_data}, q_fill.pop_front());
            end
            if (awvalid && awready) begin
                if (q_aw.size() == 0) unexpected("aw_addr", 64'(awaddr));
                else check("aw_addr", 64'(awaddr), 64'(q_aw.pop_front()));
            end
            if (wvalid && wready) begin
                if (q_w.size() == 0) unexpected("w", {30'd0, word_idx, wdata});
                else check("w{idx,data}", {30'd0, word_idx, wdata}, q_w.pop_front());
            end
            if (bvalid && bready) begin
                if (q_b.size() == 0) unexpected("b_idx", 64'(word_idx));
                else check("b_idx", 64'(word_idx), 64'(q_b.pop_front()));
            end
            if (done != 3'b000) begin
                if (q_done.size() == 0) unexpected("done", 64'(done));
                else check("done", 64'(done), 64'(q_done.pop_front()));
            end
        end
    end

    initial begin : stimulus
        int n;
        arst = 1; req = 0; addr_i = 0; addr_d = 0; addr_wb = 0; wb_base = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        arst = 0;

        // Single icache fill from an unaligned address
        push_read(3'b001, 32'h1234_5670, LW, 1);
        addr_i = 32'h1234_567C;
        req = 3'b001;
        wait_done(3'b001);
        @(negedge clk);
        check("t1_idle_grant", 64'(grant), 64'd0);
        check("t1_idle_arvalid", 64'(arvalid), 64'd0);

        // All three at once: wb, then dcache fill, then icache fill
        addr_wb = 32'h8000_1238;
        addr_d  = 32'h4000_0ABC;
        addr_i  = 32'h2000_0004;
        wb_base = 32'hC0DE_0000;
        push_write(32'h8000_1230, 32'hC0DE_0000);
        push_read(3'b010, 32'h4000_0AB0, LW, 1);
        push_read(3'b001, 32'h2000_0000, LW, 1);
        req = 3'b111;
        wait_done(3'b100);
        @(negedge clk);
        check("t2_gap1_grant", 64'(grant), 64'd0);
        @(negedge clk);
        check("t2_second_grant", 64'(grant), 64'b010);
        wait_done(3'b010);
        @(negedge clk);
        check("t2_gap2_grant", 64'(grant), 64'd0);
        @(negedge clk);
        check("t2_third_grant", 64'(grant), 64'b001);
        wait_done(3'b001);
        @(negedge clk);
        check("t2_end_grant", 64'(grant), 64'd0);

        // Write-back with W accepted before AW
        aw_dly  = 3;
        w_dly   = 1;
        addr_wb = 32'h0000_0F0C;
        wb_base = 32'h5A5A_0000;
        push_write(32'h0000_0F00, 32'h5A5A_0000);
        req = 3'b100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awvalid && n < 50);
        check("t3_c0_awvalid", 64'(awvalid), 64'd1);
        check("t3_c0_wvalid", 64'(wvalid), 64'd1);
        @(negedge clk);
        check("t3_c1_wvalid", 64'(wvalid), 64'd1);
        check("t3_c1_wready", 64'(wready), 64'd1);
        @(negedge clk);
        check("t3_c2_wvalid_dropped", 64'(wvalid), 64'd0);
        check("t3_c2_awvalid_held", 64'(awvalid), 64'd1);
        @(negedge clk);
        check("t3_c3_awvalid_held", 64'(awvalid), 64'd1);
        check("t3_c3_awready", 64'(awready), 64'd1);
        @(negedge clk);
        check("t3_c4_awvalid", 64'(awvalid), 64'd0);
        check("t3_c4_bready", 64'(bready), 64'd1);
        wait_done(3'b100);
        @(negedge clk);
        aw_dly = 0;
        w_dly  = 0;

        // Reset in the middle of beat 2 of an icache fill
        ar_dly = 3;
        addr_i = 32'h0000_2008;
        push_read(3'b001, 32'h0000_2000, 2, 0);
        req = 3'b001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(arvalid && word_idx == 2'd2) && n < 100);
        check("t4_reached_beat2", 64'(word_idx), 64'd2);
        @(posedge clk);
        #1;
        arst = 1;
        @(negedge clk);
        @(negedge clk);
        check_quiet("t4_after_reset");
        push_read(3'b001, 32'h0000_2000, LW, 1);
        @(posedge clk);
        #1;
        arst = 0;
        wait_done(3'b001);
        @(negedge clk);
        check("t4_end_grant", 64'(grant), 64'd0);

        repeat (4) @(negedge clk);
        check("q_ar_empty",   64'(q_ar.size()),   64'd0);
        check("q_fill_empty", 64'(q_fill.size()), 64'd0);
        check("q_aw_empty",   64'(q_aw.size()),   64'd0);
        check("q_w_empty",    64'(q_w.size()),    64'd0);
        check("q_b_empty",    64'(q_b.size()),    64'd0);
        check("q_done_empty", 64'(q_done.size()), 64'd0);
`ifdef MEM_ARB_ERR_EN
        check("err_clear", 64'(err), 64'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
